// File: rtl/cpudefs.sv
// Shared decode constants and the control bundle carried from decode to execute.
package cpudefs;

  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // ALU operation follows funct3 numbering so OP/OP_IMM can pass it straight through.
  typedef enum logic [2:0] {
    ALUOP_ADD  = 3'd0,
    ALUOP_SLL  = 3'd1,
    ALUOP_SLT  = 3'd2,
    ALUOP_SLTU = 3'd3,
    ALUOP_XOR  = 3'd4,
    ALUOP_SR   = 3'd5,
    ALUOP_OR   = 3'd6,
    ALUOP_AND  = 3'd7
  } aluop_t;

  typedef enum logic [1:0] {
    ALUSRC1_RS1  = 2'd0,
    ALUSRC1_PC   = 2'd1,
    ALUSRC1_ZERO = 2'd2
  } alusrc1_t;

  typedef enum logic {
    ALUSRC2_RS2 = 1'b0,
    ALUSRC2_IMM = 1'b1
  } alusrc2_t;

  typedef enum logic [1:0] {
    WBSRC_ALU = 2'd0,
    WBSRC_MEM = 2'd1,
    WBSRC_PC4 = 2'd2
  } wbsrc_t;

  // Funct carries funct3 for every legal word (load size, branch kind, mul/div op).
  typedef struct packed {
    logic     branch;
    logic     jump;
    logic     reg_write;
    logic     mem_write;
    logic     mem_read;
    logic     mul_div;
    alusrc1_t alu_src1;
    alusrc2_t alu_src2;
    wbsrc_t   wb_src;
    logic [2:0] funct;
    aluop_t   alu_op;
    logic     alu_op_alt;
  } decode_ctrl_t;

  localparam int unsigned CTRL_W = $bits(decode_ctrl_t);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I(+M) decoder: immediates, register indices, control bundle, legality.
module decode_logic
  import cpudefs::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b0
) (
  input  logic [31:0]     word,
  output logic [XLEN-1:0] imm_c,
  output logic [4:0]      rd_c,
  output logic [4:0]      rs1_c,
  output logic [4:0]      rs2_c,
  output decode_ctrl_t    ctrl_c,
  output logic            illegal_c
);

  logic [OPCODE_W-1:0] opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [31:0]         imm_i, imm_s, imm_b, imm_u, imm_j, imm32;

  assign opcode = word[6:0];
  assign funct3 = word[14:12];
  assign funct7 = word[31:25];
  assign rd_c   = word[11:7];
  assign rs1_c  = word[19:15];
  assign rs2_c  = word[24:20];

  assign imm_i = {{20{word[31]}}, word[31:20]};
  assign imm_s = {{20{word[31]}}, word[31:25], word[11:7]};
  assign imm_b = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
  assign imm_u = {word[31:12], 12'b0};
  assign imm_j = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};

  // The 32-bit format immediate is sign-extended to the datapath width.
  assign imm_c = XLEN'($signed(imm32));

  always_comb begin
    ctrl_c       = '0;
    imm32        = '0;
    illegal_c    = 1'b0;
    ctrl_c.funct = funct3;
    case (opcode)
      OPC_LOAD: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.wb_src    = WBSRC_MEM;
        ctrl_c.alu_src2  = ALUSRC2_IMM;
        imm32            = imm_i;
      end
      OPC_STORE: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.alu_src2  = ALUSRC2_IMM;
        imm32            = imm_s;
      end
      OPC_OP_IMM: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.alu_src2   = ALUSRC2_IMM;
        ctrl_c.alu_op     = aluop_t'(funct3);
        ctrl_c.alu_op_alt = (funct3 == 3'b101) && word[30];
        imm32             = imm_i;
      end
      OPC_OP: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.alu_op     = aluop_t'(funct3);
        ctrl_c.alu_op_alt = word[30];
        if (ENABLE_M && funct7 == FUNCT7_MULDIV) begin
          ctrl_c.mul_div = 1'b1;
        end else if (funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT) begin
          illegal_c = 1'b1;
        end
      end
      OPC_AUIPC: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src1  = ALUSRC1_PC;
        ctrl_c.alu_src2  = ALUSRC2_IMM;
        imm32            = imm_u;
      end
      OPC_LUI: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src1  = ALUSRC1_ZERO;
        ctrl_c.alu_src2  = ALUSRC2_IMM;
        imm32            = imm_u;
      end
      OPC_BRANCH: begin
        ctrl_c.branch     = 1'b1;
        ctrl_c.alu_op_alt = 1'b1;
        imm32             = imm_b;
      end
      OPC_JAL: begin
        ctrl_c.jump      = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src1  = ALUSRC1_PC;
        ctrl_c.alu_src2  = ALUSRC2_IMM;
        ctrl_c.wb_src    = WBSRC_PC4;
        imm32            = imm_j;
      end
      OPC_JALR: begin
        ctrl_c.jump      = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src2  = ALUSRC2_IMM;
        ctrl_c.wb_src    = WBSRC_PC4;
        imm32            = imm_i;
        illegal_c        = (funct3 != 3'b000);
      end
      default: illegal_c = 1'b1;
    endcase
    // Compressed/16-bit encodings are not supported.
    if (word[1:0] != 2'b11) illegal_c = 1'b1;
    // Illegal bundles must not cause any architectural side effect downstream.
    if (illegal_c) ctrl_c = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: combinational decode feeding a two-entry skid buffer.
module decode_stage
  import cpudefs::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b0
) (
  input  logic            i_Clock,
  input  logic            i_Reset_n,
  input  logic            i_Flush,
  input  logic            i_InstValid,
  output logic            o_InstReady,
  input  logic [31:0]     i_InstructionWord,
  input  logic [XLEN-1:0] i_PC,
  output logic            o_Valid,
  input  logic            i_Ready,
  output logic [XLEN-1:0] o_PC,
  output logic [XLEN-1:0] o_ImmediateData,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output decode_ctrl_t    o_Ctrl,
  output logic            o_IllegalInstruction
);

  localparam int unsigned BUNDLE_W = XLEN + XLEN + 15 + CTRL_W + 1;

  logic [XLEN-1:0]     dec_imm;
  logic [4:0]          dec_rd, dec_rs1, dec_rs2;
  decode_ctrl_t        dec_ctrl;
  logic                dec_illegal;
  logic [BUNDLE_W-1:0] dec_bundle, out_q, skid_q;

  buf_state_t state_q, state_d;
  logic       in_xfer, out_xfer;
  logic       load_out, load_skid, out_from_skid;

  decode_logic #(
    .XLEN     (XLEN),
    .ENABLE_M (ENABLE_M)
  ) u_decode_logic (
    .word      (i_InstructionWord),
    .imm_c     (dec_imm),
    .rd_c      (dec_rd),
    .rs1_c     (dec_rs1),
    .rs2_c     (dec_rs2),
    .ctrl_c    (dec_ctrl),
    .illegal_c (dec_illegal)
  );

  assign dec_bundle = {i_PC, dec_imm, dec_rd, dec_rs1, dec_rs2, dec_ctrl, dec_illegal};
  assign {o_PC, o_ImmediateData, o_rd, o_rs1, o_rs2, o_Ctrl, o_IllegalInstruction} = out_q;

  // Handshakes depend only on the registered state, never on downstream ready.
  assign o_InstReady = (state_q != BUF_FULL);
  assign o_Valid     = (state_q != BUF_EMPTY);
  assign in_xfer     = i_InstValid && o_InstReady;
  assign out_xfer    = o_Valid && i_Ready;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state_q <= BUF_EMPTY;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    if (i_Flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (in_xfer) begin
            state_d  = BUF_ONE;
            load_out = 1'b1;
          end
        end
        BUF_ONE: begin
          if (in_xfer && out_xfer) begin
            load_out = 1'b1;
          end else if (in_xfer) begin
            state_d   = BUF_FULL;
            load_skid = 1'b1;
          end else if (out_xfer) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (out_xfer) begin
            state_d       = BUF_ONE;
            load_out      = 1'b1;
            out_from_skid = 1'b1;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // Bundle storage: output register plus one skid entry.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)  out_q  <= out_from_skid ? skid_q : dec_bundle;
      if (load_skid) skid_q <= dec_bundle;
    end
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values 32 and 64 only.
REQ-002 Parameter ENABLE_M, default 0: 1 = decode RV32M OP encodings (funct7=0000001) as legal.
REQ-003 i_Clock  in  1  single clock; all state on rising edge.
REQ-004 i_Reset_n  in  1  reset, asynchronous, active-low.
REQ-005 i_Flush  in  1  discard all buffered instructions.
REQ-006 i_InstValid  in  1  upstream word valid.
REQ-007 o_InstReady  out  1  stage can accept a word this cycle.
REQ-008 i_InstructionWord  in  32  raw instruction.
REQ-009 i_PC  in  XLEN  address of i_InstructionWord.
REQ-010 o_Valid  out  1  decoded bundle valid.
REQ-011 i_Ready  in  1  downstream accepts the bundle.
REQ-012 o_PC  out  XLEN  PC of the bundle.
REQ-013 o_ImmediateData  out  XLEN  sign-extended immediate.
REQ-014 o_rd, o_rs1, o_rs2  out  5 each  register indices.
REQ-015 o_Ctrl  out  decode_ctrl_t  Branch, Jump, RegWrite, MemWrite, MemRead, MulDiv, AluSource1, AluSource2, WritebackSource, Funct[2:0], AluOp[2:0], AluOpAlt.
REQ-016 o_IllegalInstruction  out  1  bundle is an illegal encoding.

Function
REQ-017 Input transfer when i_InstValid && o_InstReady; output transfer when o_Valid && i_Ready.
REQ-018 Two-entry skid buffer (output register + skid register), states EMPTY, ONE, FULL; o_InstReady = (state != FULL), o_Valid = (state != EMPTY), both decoded from registered state only.
REQ-019 EMPTY: input transfer -> ONE, bundle on outputs next cycle (latency 1).
REQ-020 ONE: input+output transfer -> ONE with new bundle; input only -> FULL (new word to skid); output only -> EMPTY.
REQ-021 FULL: output transfer -> ONE, skid bundle moves to output register next cycle; no input accepted.
REQ-022 Order preserved; no bundle duplicated or dropped except by flush.
REQ-023 i_Flush=1 -> next state EMPTY regardless of handshakes; word presented in the same cycle discarded.
REQ-024 Output bundle held stable while o_Valid && !i_Ready.
REQ-025 Decode is combinational on the incoming word; registered bundle stored per entry.
REQ-026 Immediates per RISC-V I/S/B/U/J formats, sign-extended from bit 31 to XLEN; U-type bits [11:0]=0 then sign-extended.
REQ-027 LOAD: MemRead, WB=MEM, AluOp=ADD, Alt=0, I-imm. STORE: MemWrite, RegWrite=0, S-imm. OP_IMM: Src2=IMM, I-imm; Alt=bit30 only for funct3=101, else 0. OP: Src1=RS1, Src2=RS2, Alt=bit30. AUIPC: Src1=PC, Src2=IMM. LUI: Src1=ZERO, Src2=IMM. BRANCH: Branch, RegWrite=0, B-imm, AluOp=ADD, Alt=1. JAL: Jump, J-imm, Src1=PC. JALR: Jump, I-imm, Src1=RS1.
REQ-028 Illegal when word[1:0]!=2'b11, unknown opcode, OP funct7 not in {0000000,0100000} (plus 0000001 if ENABLE_M), or JALR funct3!=000.
REQ-029 Illegal bundles still transfer with o_IllegalInstruction=1 and Branch, Jump, RegWrite, MemWrite, MemRead, MulDiv all 0.
REQ-030 ENABLE_M=1 and OP funct7=0000001: MulDiv=1, Funct=funct3, RegWrite=1.

Reset
REQ-031 i_Reset_n low asynchronously forces state EMPTY: o_Valid=0, o_InstReady=1, all bundle registers 0, including mid-transfer.
REQ-032 First input transfer possible on the first rising edge after i_Reset_n deasserts.

Structure
REQ-033 cpudefs package holds opcode, ALUOP, ALUSRC1 (RS1/PC/ZERO), ALUSRC2, WBSRC constants and decode_ctrl_t.
REQ-034 Combinational decode in one sub-module decode_logic, parametrised by XLEN and ENABLE_M; decode_stage holds buffer and state machine only.

Verification
REQ-035 XLEN=64, push 0xFFF00093 (ADDI x1,x0,-1), i_Ready=1 -> next cycle o_Valid=1, rd=1, imm=0xFFFF_FFFF_FFFF_FFFF, Src2=IMM, RegWrite=1.
REQ-036 i_Ready=0, push A then B -> after B o_InstReady=0, C held upstream; i_Ready=1 -> A, B, C in order, one per cycle.
REQ-037 State FULL, i_Flush=1 with i_InstValid=1 -> next cycle o_Valid=0, o_InstReady=1; flushed words never appear.
REQ-038 0x022081B3 (MUL x3,x1,x2): ENABLE_M=0 -> illegal=1, RegWrite=0; ENABLE_M=1 -> legal, MulDiv=1, rd=3.
REQ-039 0x008000EF (JAL x1,+8), i_PC=0x100 -> Jump=1, imm=8, o_PC=0x100, Src1=PC.
REQ-040 i_Reset_n low while FULL with i_Ready=0 -> o_Valid=0, o_InstReady=1 immediately, without a clock edge.
